// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
//
// Transmit half of the UART core. Bytes written by the control side are held
// in a small FIFO and serialised onto Tx_o as:
//   start bit (0), 8 data bits, optional parity bit, one stop bit (1).
// Every bit lasts one BaudSig_i period. The FSM only advances on cycles where
// BaudSig_i is high.
//
// Build option:
//   UART_TX_PARITY_EN  - when defined, the parity logic and the PARITYBIT state
//                        are built in. When undefined, p_ParityEnable_i and
//                        ParityMethod_i are ignored and every frame is
//                        10 bit periods long.
//
// Parameters:
//   DEPTH  FIFO depth in bytes (power of 2, 2..256)
//   AW     FIFO address width, log2(DEPTH)
//
// Ports:
//   clk               system clock
//   rst               asynchronous reset, active low
//   Data_i            byte to enqueue
//   n_We_i            FIFO write strobe, active low, one clk per byte
//   n_Clr_i           FIFO clear, active low (wins over a same-cycle write)
//   p_Enable_i        transmit enable; high allows new bytes to start
//   BaudSig_i         one-clk pulse per bit period
//   p_ParityEnable_i  insert a parity bit
//   p_BigEnd_i        1: bit7 first, 0: bit0 first
//   ParityMethod_i    0: even, 1: odd
//   p_Empty_o         FIFO empty
//   p_Full_o          FIFO full
//   p_Over_o          sticky overflow: write attempted while full
//   TxFifoLevel_o     bytes held in the FIFO
//   p_Busy_o          FSM is not in INTERVAL
//   p_ByteSent_o      one-clk pulse after each stop bit ends
//   Tx_o              serial output, idle high
// -----------------------------------------------------------------------------
module uart_tx_core #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    Data_i,
    input  logic          n_We_i,
    input  logic          n_Clr_i,
    input  logic          p_Enable_i,
    input  logic          BaudSig_i,
    input  logic          p_ParityEnable_i,
    input  logic          p_BigEnd_i,
    input  logic          ParityMethod_i,
    output logic          p_Empty_o,
    output logic          p_Full_o,
    output logic          p_Over_o,
    output logic [AW:0]   TxFifoLevel_o,
    output logic          p_Busy_o,
    output logic          p_ByteSent_o,
    output logic          Tx_o
);

    // One-hot state encodings; kept identical whether or not parity is built.
    localparam logic [4:0] INTERVAL  = 5'b0_0001;
    localparam logic [4:0] STARTBIT  = 5'b0_0010;
    localparam logic [4:0] DATABITS  = 5'b0_0100;
`ifdef UART_TX_PARITY_EN
    localparam logic [4:0] PARITYBIT = 5'b0_1000;
`endif
    localparam logic [4:0] STOPBIT   = 5'b1_0000;

    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    // -------------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // -------------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          over_q, over_d;

    logic          wr_acc;     // write accepted this cycle
    logic          pop;        // FSM takes the head byte this cycle
    logic [7:0]    head_byte;

    // Acceptance looks at the full flag as it stood at the start of the cycle,
    // so a pop in the same cycle does not make room for a write to a full FIFO.
    // A clear suppresses the write entirely.
    assign wr_acc    = !n_We_i && !full_q && n_Clr_i;

    // The head byte is read combinationally so it can be loaded into the
    // shift register on the same BaudSig that decides to start the frame.
    assign head_byte = mem_q[rd_ptr_q];

    // Storage array has no reset: contents are discarded by resetting the
    // pointers and level, which keeps the array mappable to distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= Data_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        over_d   = over_q;

        if (!n_Clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            over_d   = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            // Simultaneous write and pop cancel out on the level.
            case ({wr_acc, pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
            if (!n_We_i && full_q) begin
                over_d = 1'b1;
            end
        end

        empty_d = (level_d == '0);
        full_d  = (level_d == LVL_FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            over_q   <= over_d;
        end
    end

    // -------------------------------------------------------------------------
    // Transmit FSM
    // -------------------------------------------------------------------------
    logic [4:0] state_q, state_d;
    logic [7:0] shift_q, shift_d;   // remaining data bits, next bit at the edge
    logic [2:0] cnt_q, cnt_d;       // data bits already sent minus one
    logic       big_q, big_d;       // bit order latched for the current byte
    logic       tx_q, tx_d;
    logic       sent_q, sent_d;
    logic       busy_q, busy_d;

`ifdef UART_TX_PARITY_EN
    logic       par_en_q, par_en_d;
    logic       par_bit_q, par_bit_d;
`else
    // Parity controls have no effect in this build.
    logic       unused_parity_cfg;
    assign unused_parity_cfg = p_ParityEnable_i ^ ParityMethod_i;
`endif

    logic       can_start;
    logic       start;
    logic       data_bit;
    logic [7:0] shift_nxt;

    // Starting a byte needs data, permission, and no clear in progress
    // (a clear wins, so the head byte it discards must not be sent).
    assign can_start = !empty_q && p_Enable_i && n_Clr_i;

    // A new byte can be loaded from idle, or straight out of the stop bit so
    // consecutive frames run back to back with no idle bit between them.
    assign start = BaudSig_i && can_start &&
                   ((state_q == INTERVAL) || (state_q == STOPBIT));
    assign pop   = start;

    // The shift register always presents the next bit at the end matching the
    // latched bit order, then moves toward that end.
    assign data_bit  = big_q ? shift_q[7] : shift_q[0];
    assign shift_nxt = big_q ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        big_d   = big_q;
        tx_d    = tx_q;
        sent_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif

        if (BaudSig_i) begin
            case (state_q)
                INTERVAL: begin
                    tx_d = 1'b1;
                end
                STARTBIT: begin
                    tx_d    = data_bit;
                    shift_d = shift_nxt;
                    cnt_d   = '0;
                    state_d = DATABITS;
                end
                DATABITS: begin
                    if (cnt_q != 3'd7) begin
                        tx_d    = data_bit;
                        shift_d = shift_nxt;
                        cnt_d   = cnt_q + 3'd1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            tx_d    = par_bit_q;
                            state_d = PARITYBIT;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOPBIT;
                        end
`else
                        tx_d    = 1'b1;
                        state_d = STOPBIT;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITYBIT: begin
                    tx_d    = 1'b1;
                    state_d = STOPBIT;
                end
`endif
                STOPBIT: begin
                    sent_d  = 1'b1;
                    tx_d    = 1'b1;
                    state_d = INTERVAL;
                end
                default: begin
                    // Unreachable encodings fall back to idle.
                    tx_d    = 1'b1;
                    state_d = INTERVAL;
                end
            endcase

            // Load overrides the idle/stop outcome above. Configuration is
            // latched here so mid-byte changes only affect the next byte.
            if (start) begin
                shift_d = head_byte;
                big_d   = p_BigEnd_i;
`ifdef UART_TX_PARITY_EN
                par_en_d  = p_ParityEnable_i;
                par_bit_d = (^head_byte) ^ ParityMethod_i;
`endif
                tx_d    = 1'b0;
                state_d = STARTBIT;
            end
        end

        busy_d = (state_d != INTERVAL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INTERVAL;
            shift_q <= '0;
            cnt_q   <= '0;
            big_q   <= 1'b0;
            tx_q    <= 1'b1;
            sent_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            big_q   <= big_d;
            tx_q    <= tx_d;
            sent_q  <= sent_d;
            busy_q  <= busy_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs (all driven straight from registers)
    // -------------------------------------------------------------------------
    assign p_Empty_o     = empty_q;
    assign p_Full_o      = full_q;
    assign p_Over_o      = over_q;
    assign TxFifoLevel_o = level_q;
    assign p_Busy_o      = busy_q;
    assign p_ByteSent_o  = sent_q;
    assign Tx_o          = tx_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_core
//
// Directed bench for uart_tx_core. BaudSig_i pulses once every 16 clocks.
// Frames are captured by sampling Tx_o in the middle of each bit and packed
// first-sent-bit-at-MSB, then compared with hand-computed frames.
// -----------------------------------------------------------------------------
module tb_uart_tx_core;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

`ifdef UART_TX_PARITY_EN
    localparam int          NB_PAR   = 11;
    localparam logic [10:0] EXP_EVEN = 11'b00000001101;
    localparam logic [10:0] EXP_ODD  = 11'b00000001111;
`else
    localparam int          NB_PAR   = 10;
    localparam logic [10:0] EXP_EVEN = 11'b00000000111;
    localparam logic [10:0] EXP_ODD  = 11'b00000000111;
`endif

    logic          clk;
    logic          rst;
    logic [7:0]    Data_i;
    logic          n_We_i;
    logic          n_Clr_i;
    logic          p_Enable_i;
    logic          BaudSig_i;
    logic          p_ParityEnable_i;
    logic          p_BigEnd_i;
    logic          ParityMethod_i;
    logic          p_Empty_o;
    logic          p_Full_o;
    logic          p_Over_o;
    logic [AW:0]   TxFifoLevel_o;
    logic          p_Busy_o;
    logic          p_ByteSent_o;
    logic          Tx_o;

    int n_checks = 0;
    int n_pass   = 0;
    int sent_cnt = 0;
    int baud_cnt = 0;
    int gap;

    uart_tx_core #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .Data_i           (Data_i),
        .n_We_i           (n_We_i),
        .n_Clr_i          (n_Clr_i),
        .p_Enable_i       (p_Enable_i),
        .BaudSig_i        (BaudSig_i),
        .p_ParityEnable_i (p_ParityEnable_i),
        .p_BigEnd_i       (p_BigEnd_i),
        .ParityMethod_i   (ParityMethod_i),
        .p_Empty_o        (p_Empty_o),
        .p_Full_o         (p_Full_o),
        .p_Over_o         (p_Over_o),
        .TxFifoLevel_o    (TxFifoLevel_o),
        .p_Busy_o         (p_Busy_o),
        .p_ByteSent_o     (p_ByteSent_o),
        .Tx_o             (Tx_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running baud pulse, one clock wide, every 16 clocks.
    initial begin
        BaudSig_i = 1'b0;
        forever begin
            @(negedge clk);
            baud_cnt  = (baud_cnt + 1) % 16;
            BaudSig_i = (baud_cnt == 15);
        end
    end

    // Count completed-byte pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (p_ByteSent_o) sent_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got=%0h exp=%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        @(negedge clk);
        Data_i = d;
        n_We_i = 1'b0;
        @(negedge clk);
        n_We_i = 1'b1;
    endtask

    // Wait (bounded) for a start bit, then sample each bit mid-period.
    task automatic capture_frame(input string tag, input int nbits,
                                 input logic [10:0] exp, output int wait_cyc);
        logic [10:0] bits;
        bits     = '0;
        wait_cyc = 0;
        while (Tx_o !== 1'b0 && wait_cyc < 300) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (Tx_o !== 1'b0) begin
            check({tag, "_start"}, 32'(Tx_o), 32'd0);
            return;
        end
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bits = {bits[9:0], Tx_o};
            if (i != nbits - 1) repeat (16) @(negedge clk);
        end
        check(tag, 32'(bits), 32'(exp));
    endtask

    initial begin
        rst              = 1'b0;
        Data_i           = 8'h00;
        n_We_i           = 1'b1;
        n_Clr_i          = 1'b1;
        p_Enable_i       = 1'b1;
        p_ParityEnable_i = 1'b0;
        p_BigEnd_i       = 1'b0;
        ParityMethod_i   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx",    32'(Tx_o),          32'd1);
        check("rst_busy",  32'(p_Busy_o),      32'd0);
        check("rst_sent",  32'(p_ByteSent_o),  32'd0);
        check("rst_empty", 32'(p_Empty_o),     32'd1);
        check("rst_full",  32'(p_Full_o),      32'd0);
        check("rst_over",  32'(p_Over_o),      32'd0);
        check("rst_level", 32'(TxFifoLevel_o), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // 0xA5, bit0 first, no parity: 0 10100101 1
        write_byte(8'hA5);
        capture_frame("a5_frame", 10, 11'b00101001011, gap);
        repeat (20) @(negedge clk);
        check("a5_sent", 32'(sent_cnt), 32'd1);
        check("a5_busy", 32'(p_Busy_o), 32'd0);
        check("a5_idle", 32'(Tx_o),     32'd1);

        // 0x03, bit7 first, even then odd parity
        p_BigEnd_i       = 1'b1;
        p_ParityEnable_i = 1'b1;
        ParityMethod_i   = 1'b0;
        write_byte(8'h03);
        capture_frame("par_even", NB_PAR, EXP_EVEN, gap);
        repeat (20) @(negedge clk);
        ParityMethod_i = 1'b1;
        write_byte(8'h03);
        capture_frame("par_odd", NB_PAR, EXP_ODD, gap);
        repeat (20) @(negedge clk);
        check("par_sent", 32'(sent_cnt), 32'd3);

        // Three queued bytes go out back to back
        p_ParityEnable_i = 1'b0;
        p_BigEnd_i       = 1'b0;
        p_Enable_i       = 1'b0;
        write_byte(8'h55);
        write_byte(8'h0F);
        write_byte(8'h81);
        check("q3_level", 32'(TxFifoLevel_o), 32'd3);
        check("q3_busy0", 32'(p_Busy_o),      32'd0);
        p_Enable_i = 1'b1;
        capture_frame("q3_f1", 10, 11'b00101010101, gap);
        check("q3_lvl2", 32'(TxFifoLevel_o), 32'd2);
        capture_frame("q3_f2", 10, 11'b00111100001, gap);
        check("q3_gap2", 32'(gap <= 9), 32'd1);
        check("q3_lvl1", 32'(TxFifoLevel_o), 32'd1);
        capture_frame("q3_f3", 10, 11'b00100000011, gap);
        check("q3_gap3", 32'(gap <= 9), 32'd1);
        check("q3_lvl0", 32'(TxFifoLevel_o), 32'd0);
        check("q3_busy1", 32'(p_Busy_o),     32'd1);
        repeat (20) @(negedge clk);
        check("q3_busyend", 32'(p_Busy_o), 32'd0);
        check("q3_sent",    32'(sent_cnt), 32'd6);

        // Overflow with DEPTH+1 writes, then clear
        p_Enable_i = 1'b0;
        @(negedge clk);
        n_We_i = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            Data_i = 8'(i);
            @(negedge clk);
        end
        n_We_i = 1'b1;
        check("ov_full",  32'(p_Full_o),      32'd1);
        check("ov_over",  32'(p_Over_o),      32'd1);
        check("ov_level", 32'(TxFifoLevel_o), 32'(DEPTH));
        check("ov_empty", 32'(p_Empty_o),     32'd0);
        n_Clr_i = 1'b0;
        @(negedge clk);
        n_Clr_i = 1'b1;
        check("clr_level", 32'(TxFifoLevel_o), 32'd0);
        check("clr_over",  32'(p_Over_o),      32'd0);
        check("clr_empty", 32'(p_Empty_o),     32'd1);
        check("clr_full",  32'(p_Full_o),      32'd0);
        check("clr_tx",    32'(Tx_o),          32'd1);
        p_Enable_i = 1'b1;
        repeat (40) @(negedge clk);
        check("clr_txidle", 32'(Tx_o),     32'd1);
        check("clr_busy",   32'(p_Busy_o), 32'd0);
        check("clr_sent",   32'(sent_cnt), 32'd6);

        // Asynchronous reset in the middle of the data bits
        write_byte(8'h00);
        write_byte(8'h00);
        gap = 0;
        while (Tx_o !== 1'b0 && gap < 300) begin
            @(negedge clk);
            gap++;
        end
        repeat (40) @(negedge clk);
        check("mr_pre_tx",    32'(Tx_o),      32'd0);
        check("mr_pre_empty", 32'(p_Empty_o), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("mr_tx",    32'(Tx_o),          32'd1);
        check("mr_empty", 32'(p_Empty_o),     32'd1);
        check("mr_busy",  32'(p_Busy_o),      32'd0);
        check("mr_level", 32'(TxFifoLevel_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        write_byte(8'hA5);
        capture_frame("mr_frame", 10, 11'b00101001011, gap);
        repeat (20) @(negedge clk);
        check("mr_sent", 32'(sent_cnt), 32'd7);

        // Bit order change mid-byte affects only the next byte
        p_Enable_i = 1'b0;
        p_BigEnd_i = 1'b0;
        write_byte(8'h01);
        write_byte(8'h01);
        p_Enable_i = 1'b1;
        fork
            capture_frame("be_f1", 10, 11'b00100000001, gap);
            begin
                repeat (60) @(negedge clk);
                p_BigEnd_i = 1'b1;
            end
        join
        capture_frame("be_f2", 10, 11'b00000000011, gap);
        repeat (20) @(negedge clk);
        check("be_sent", 32'(sent_cnt), 32'd9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
